// File: rtl/cpu_trace_buffer.sv
// Execution-trace capture buffer: snapshots NCH CPU channels with a timestamp into DEPTH records.
// Latency: a record written on one edge is readable from the next edge; readout gives one record per cycle.
// Backpressure: rd_data/rd_valid hold while rd_ready is low; count only drops on a handshake.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   ch_data, sample_en  watched channels (channel 0 in LSBs) and capture strobe
//   mode, arm           0 = stop-on-full, 1 = circular with trigger; arm starts a capture from IDLE
//   trig_in, post_cnt   trigger (circular mode, ARMED only) and post-trigger sample count
//   abort               back to IDLE from any state
//   rd_data/valid/ready oldest record {timestamp, ch_data} and its handshake
//   count, overflow     records held; sticky overwrite flag (cleared on arm)
//   done, state         readout phase flag; IDLE=0, ARMED=1, POST=2, DONE=3
module cpu_trace_buffer #(
    parameter int WIDTH  = 16,
    parameter int NCH    = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int TS_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH*WIDTH-1:0]      ch_data,
    input  logic                      sample_en,
    input  logic                      mode,
    input  logic                      arm,
    input  logic                      trig_in,
    input  logic [ADDR_W-1:0]         post_cnt,
    input  logic                      abort,
    output logic [TS_W+NCH*WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [ADDR_W:0]           count,
    output logic                      overflow,
    output logic                      done,
    output logic [1:0]                state
);

    localparam int REC_W = TS_W + NCH*WIDTH;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] REM_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] remaining;
    logic              mode_q;
    logic              arm_acc;
    logic              wr_en;
    logic              trig_acc;
    logic              pop;
    logic              full;
    logic [REC_W-1:0]  mem [DEPTH];

    // Oldest record sits count entries behind the write pointer; when full the
    // low bits of count are zero so rd_ptr == wr_ptr, which is the oldest slot.
    assign rd_ptr = wr_ptr - count[ADDR_W-1:0];
    assign full   = (count == CNT_FULL);
    assign state  = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm_acc) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (!mode_q) begin
                        // the write that fills the last free slot ends the capture
                        if (wr_en && count == CNT_LAST) state_d = S_DONE;
                    end else if (trig_in) begin
                        state_d = (post_cnt == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (wr_en && remaining == REM_ONE) state_d = S_DONE;
                end
                S_DONE: begin
                    if (pop && count == CNT_ONE) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output / strobe logic
    always_comb begin
        arm_acc  = (state_q == S_IDLE) && arm && !abort;
        wr_en    = sample_en && !abort && (state_q == S_ARMED || state_q == S_POST);
        trig_acc = (state_q == S_ARMED) && mode_q && trig_in && !abort;
        done     = (state_q == S_DONE);
        rd_valid = done && (count != '0);
        pop      = rd_valid && rd_ready && !abort;
        rd_data  = rd_valid ? mem[rd_ptr] : '0;
    end

    // Control datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            ts        <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            // restart the timebase so the first ARMED cycle stamps zero
            ts <= arm_acc ? '0 : ts + 1'b1;

            // the trigger sample itself is not part of the post-trigger count
            if (trig_acc) begin
                remaining <= post_cnt;
            end else if (wr_en && state_q == S_POST) begin
                remaining <= remaining - 1'b1;
            end

            if (abort) begin
                count <= '0;
            end else if (arm_acc) begin
                count    <= '0;
                wr_ptr   <= '0;
                overflow <= 1'b0;
                mode_q   <= mode;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                if (pop) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Record storage
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {ts, ch_data};
        end
    end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Parametrised, synthesizable execution-trace capture block for the RISC16 CPU. It snapshots NCH watched CPU channels (IR plus selected registers) into a DEPTH-entry buffer. Each record carries a cycle timestamp. Records are read back oldest-first over a valid/ready port. Capture runs in stop-on-full mode or circular pre/post-trigger mode, so it replaces per-tick simulation printouts with on-chip history usable in both simulation and hardware.

## Interface
- WIDTH, 16, bits per watched channel
- NCH, 4, number of channels (default: ir, r1, r2, r3)
- DEPTH, 8, records held; power of two, ≥2
- ADDR_W, 3, log2(DEPTH)
- TS_W, 16, timestamp width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ch_data  in  NCH*WIDTH  watched channels, channel 0 in LSBs
- sample_en  in  1  capture strobe, one record per asserted cycle
- mode  in  1  0 = stop-on-full, 1 = circular with trigger; sampled on arm
- arm  in  1  start capture, honoured only in IDLE
- trig_in  in  1  trigger, honoured only in ARMED with mode=1
- post_cnt  in  ADDR_W  post-trigger samples; sampled on trigger
- abort  in  1  return to IDLE from any state
- rd_data  out  TS_W+NCH*WIDTH  {timestamp, ch_data} of oldest record
- rd_valid  out  1  rd_data holds a valid record
- rd_ready  in  1  consumer accepts rd_data
- count  out  ADDR_W+1  records currently held
- overflow  out  1  sticky: a record was overwritten (mode 1)
- done  out  1  capture complete, readout phase
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3

## Operation
- Reset values: state=IDLE; count, wr_ptr, ts, remaining, overflow, done, rd_valid all 0. rd_data=0 while count=0.
- ts: free-running counter, increments every cycle, wraps at 2^TS_W. It is forced to 0 on the cycle arm is accepted. The first ARMED cycle therefore stamps ts=0.
- Write: on sample_en in ARMED/POST, mem[wr_ptr]={ts,ch_data}; wr_ptr=wr_ptr+1 mod DEPTH; count=min(count+1,DEPTH).
- IDLE: sample_en, trig_in, rd_ready ignored. arm → ARMED, latches mode, clears count/wr_ptr/overflow.
- ARMED, mode 0: writes until count reaches DEPTH; the write that fills the buffer → DONE. trig_in ignored.
- ARMED, mode 1: writes wrap. A write with count==DEPTH overwrites the oldest record and sets overflow.
  - trig_in: the same-cycle sample (if sample_en) is captured as the trigger record. remaining=post_cnt.
  - If post_cnt==0 → DONE, otherwise → POST.
- POST: each write decrements remaining; the write taking remaining to 0 → DONE. Overwrite/overflow rules as ARMED. trig_in ignored.
- DONE: done=1; writes blocked.
  - rd_ptr=(wr_ptr−count) mod DEPTH; rd_data=mem[rd_ptr]; rd_valid=(count>0).
  - On rd_valid&&rd_ready: count decrements. The pop of the last record → IDLE, done=0.
- abort: highest priority after rst; any state → IDLE next cycle, count=0, rd_valid=0, done=0. overflow is preserved until the next arm.
- arm outside IDLE is ignored; an arm coincident with abort is ignored.
- count never exceeds DEPTH; pointer arithmetic is modulo DEPTH.

## Timing
- Capture latency: a record written at edge N is readable from edge N+1.
- DONE is entered on the edge of the completing write; rd_valid=1 in the first DONE cycle.
- Readout is one record per cycle with rd_ready held high. rd_data changes only on the edge after a handshake.
- rd_data and rd_valid are stable while rd_valid=1 and rd_ready=0.
- State transitions take effect on the clock edge after the causing input. rst overrides all inputs in the same cycle.

## Test plan
- Reset: assert rst 2 cycles mid-capture → state=0, count=0, done=0, overflow=0, rd_valid=0, rd_data=0.
- Mode 0 fill: arm, then sample_en every cycle with ch_data channel0=0x100+k.
  - Required: done after 8 samples, count=8.
  - Readout yields ts 0..7 and channel0 0x100..0x107 in order, then IDLE.
- Mode 1 wrap: sample_en every cycle, trig_in on sample 20, post_cnt=3.
  - Required: DONE after sample 23, overflow=1.
  - Readout returns samples 16..23 (ts 16..23).
- post_cnt=0: trigger on sample 5 with sample_en → DONE next edge, count=6, last record read is sample 5.
- Backpressure: in DONE, toggle rd_ready 1,0,0,1,…
  - Required: rd_data held while not ready; every record delivered exactly once; count decrements only on handshakes.
- Abort/ignored inputs:
  - abort in POST → IDLE next cycle, count=0, rd_valid=0.
  - arm during DONE does not restart capture.
  - sample_en gaps of 2 cycles produce ts steps of 3.
